// File: rtl/falling_char_engine.sv
// Falling-character game engine: a table of character slots that spawn, fall once per
// movement step and are killed by matching keystrokes, plus a two-stage glyph render pipe.
module falling_char_engine #(
  parameter int SLOTS     = 16,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 16,
  parameter int SPD_W     = 4,
  parameter int FRAME_DIV = 1
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       spawn_valid,
  output logic                       spawn_ready,
  input  logic [7:0]                 spawn_char,
  input  logic [9:0]                 spawn_x,
  input  logic [SPD_W-1:0]           spawn_speed,
  input  logic                       key_valid,
  input  logic [7:0]                 key_char,
  input  logic [9:0]                 h_addr,
  input  logic [9:0]                 v_addr,
  output logic [11:0]                rom_addr,
  input  logic [11:0]                rom_data,
  output logic                       pix_on,
  output logic                       hit,
  output logic                       miss,
  output logic                       wrong,
  output logic [$clog2(SLOTS+1)-1:0] active_cnt,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
);

  localparam int          CNT_W   = $clog2(SLOTS+1);
  localparam logic [9:0]  X_MAX   = 10'(H_RES - CHAR_W);
  localparam logic [10:0] Y_MAX   = 11'(V_RES - CHAR_H);
  localparam logic [7:0]  DIV_TOP = 8'(FRAME_DIV - 1);

  logic [SLOTS-1:0] act;
  logic [7:0]       chr [SLOTS];
  logic [9:0]       xs  [SLOTS];
  logic [9:0]       ys  [SLOTS];
  logic [SPD_W-1:0] spd [SLOTS];
  logic [7:0]       fcnt;

  logic             frame_tick, step, spawn_fire, kill_any;
  logic             sp_found, k_found;
  logic [SLOTS-1:0] spawn_oh, kill_oh, exit_oh, act_nxt;
  logic [10:0]      ny [SLOTS];
  logic [CNT_W-1:0] cnt_nxt;
  logic [9:0]       sx;

  logic             r_found;
  logic [7:0]       r_chr;
  logic [3:0]       r_row, r_col;
  logic [9:0]       dh, dv;
  logic             sel, sel_d;
  logic [3:0]       col, col_d;

  assign frame_tick  = (h_addr == 10'd0) && (v_addr == 10'(V_RES));
  assign step        = frame_tick && (fcnt == DIV_TOP);
  assign spawn_ready = ~(&act) & ~step;
  assign spawn_fire  = spawn_valid & spawn_ready;
  assign kill_any    = |kill_oh;
  assign sx          = (spawn_x > X_MAX) ? X_MAX : spawn_x;

  always_comb begin
    spawn_oh = '0;
    kill_oh  = '0;
    sp_found = 1'b0;
    k_found  = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!act[i] && !sp_found) begin
        spawn_oh[i] = 1'b1;
        sp_found    = 1'b1;
      end
      if (key_valid && act[i] && (chr[i] == key_char) && !k_found) begin
        kill_oh[i] = 1'b1;
        k_found    = 1'b1;
      end
    end
  end

  // A slot killed on the step cycle is never also counted as leaving the screen.
  always_comb begin
    exit_oh = '0;
    for (int i = 0; i < SLOTS; i++) begin
      ny[i]      = {1'b0, ys[i]} + 11'(spd[i]);
      exit_oh[i] = step & act[i] & ~kill_oh[i] & (ny[i] > Y_MAX);
    end
  end

  always_comb begin
    act_nxt = (act & ~kill_oh & ~exit_oh) | (spawn_fire ? spawn_oh : '0);
    cnt_nxt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(act_nxt[i]);
    end
  end

  // Offsets are taken only when the scan is at or past the slot origin, so no wraparound.
  always_comb begin
    r_found = 1'b0;
    r_chr   = '0;
    r_row   = '0;
    r_col   = '0;
    dh      = '0;
    dv      = '0;
    for (int i = 0; i < SLOTS; i++) begin
      dh = h_addr - xs[i];
      dv = v_addr - ys[i];
      if (!r_found && act[i] && (h_addr >= xs[i]) && (dh < 10'(CHAR_W)) &&
          (v_addr >= ys[i]) && (dv < 10'(CHAR_H))) begin
        r_found = 1'b1;
        r_chr   = chr[i];
        r_row   = dv[3:0];
        r_col   = dh[3:0];
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      act        <= '0;
      fcnt       <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      wrong      <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      active_cnt <= '0;
      rom_addr   <= '0;
      sel        <= 1'b0;
      col        <= '0;
      sel_d      <= 1'b0;
      col_d      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        chr[i] <= '0;
        xs[i]  <= '0;
        ys[i]  <= '0;
        spd[i] <= '0;
      end
    end else begin
      if (frame_tick) fcnt <= (fcnt == DIV_TOP) ? 8'd0 : fcnt + 8'd1;
      for (int i = 0; i < SLOTS; i++) begin
        if (spawn_fire && spawn_oh[i]) begin
          chr[i] <= spawn_char;
          xs[i]  <= sx;
          ys[i]  <= '0;
          spd[i] <= spawn_speed;
        end else if (step && act[i]) begin
          ys[i]  <= ny[i][9:0];
        end
      end
      act        <= act_nxt;
      active_cnt <= cnt_nxt;
      hit        <= kill_any;
      wrong      <= key_valid & ~kill_any;
      miss       <= |exit_oh;
      if (kill_any && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if ((|exit_oh) && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      sel        <= r_found;
      rom_addr   <= r_found ? {r_chr, r_row} : 12'd0;
      col        <= r_found ? r_col : 4'd0;
      sel_d      <= sel;
      col_d      <= col;
    end
  end

  // rom_data lines up with sel_d/col_d: it arrives one cycle after rom_addr.
  assign pix_on = sel_d & rom_data[col_d];

endmodule

// File: tb/tb_falling_char_engine.sv
// Bench for falling_char_engine: directed stimulus pushes cycle-stamped expectations
// into a scoreboard queue that a negedge monitor pops and compares.
module tb_falling_char_engine;
  localparam int SPD_W = 4;
  localparam int S_RDY = 0, S_ACT = 1, S_HIT = 2, S_MISS = 3, S_WRONG = 4;
  localparam int S_HCNT = 5, S_MCNT = 6, S_PIX = 7, S_ROM = 8;

  logic             pclk = 1'b0;
  logic             reset = 1'b1;
  logic             spawn_valid = 1'b0;
  logic [7:0]       spawn_char = '0;
  logic [9:0]       spawn_x = '0;
  logic [SPD_W-1:0] spawn_speed = '0;
  logic             key_valid = 1'b0;
  logic [7:0]       key_char = '0;
  logic [9:0]       h_addr = 10'd1023;
  logic [9:0]       v_addr = 10'd1023;
  logic [11:0]      rom_data = '0;
  logic             spawn_ready, pix_on, hit, miss, wrong;
  logic [11:0]      rom_addr;
  logic [4:0]       active_cnt;
  logic [15:0]      hit_cnt, miss_cnt;

  falling_char_engine #(
    .SLOTS(16), .H_RES(640), .V_RES(480), .CHAR_W(9), .CHAR_H(16),
    .SPD_W(SPD_W), .FRAME_DIV(1)
  ) dut (
    .pclk(pclk), .reset(reset),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_char(spawn_char),
    .spawn_x(spawn_x), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_char(key_char),
    .h_addr(h_addr), .v_addr(v_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_on(pix_on),
    .hit(hit), .miss(miss), .wrong(wrong),
    .active_cnt(active_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 pclk = ~pclk;

  function automatic logic [11:0] font(input logic [11:0] a);
    return {a[3:0], a[11:4]} ^ 12'h5A3;
  endfunction

  always @(posedge pclk) rom_data <= font(rom_addr);

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_act;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic int get_sig(input int s);
    case (s)
      S_RDY:   return int'(spawn_ready);
      S_ACT:   return int'(active_cnt);
      S_HIT:   return int'(hit);
      S_MISS:  return int'(miss);
      S_WRONG: return int'(wrong);
      S_HCNT:  return int'(hit_cnt);
      S_MCNT:  return int'(miss_cnt);
      S_PIX:   return int'(pix_on);
      default: return int'(rom_addr);
    endcase
  endfunction

  always @(negedge pclk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        mon_act = get_sig(sbq[i].sig);
        checks++;
        if (mon_act != sbq[i].val) begin
          errors++;
          $display("FAIL %s: got %0h want %0h (cycle %0d)", sbq[i].nm, mon_act, sbq[i].val, cyc);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled, want %0h (cycle %0d)", sbq[i].nm, sbq[i].val, sbq[i].cyc);
        sbq.delete(i);
      end
    end
  end

  // Reference slot picture, filled in by hand for each scenario.
  logic [7:0] m_chr [16];
  int         m_x   [16];
  int         m_y   [16];
  bit         m_act [16];

  function automatic void ref_render(input int h, input int v, output bit f,
                                     output logic [11:0] addr, output int col);
    f = 0; addr = '0; col = 0;
    for (int i = 0; i < 16; i++) begin
      if (!f && m_act[i] && h >= m_x[i] && h < m_x[i] + 9 && v >= m_y[i] && v < m_y[i] + 16) begin
        f    = 1;
        addr = {m_chr[i], 4'(v - m_y[i])};
        col  = h - m_x[i];
      end
    end
  endfunction

  task automatic want(input int dly, input int sig, input int val, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.sig = sig; e.val = val; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clr();
    spawn_valid = 1'b0;
    key_valid   = 1'b0;
    h_addr      = 10'd1023;
    v_addr      = 10'd1023;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_act[i] = 0;
  endtask

  task automatic model_set(input int i, input logic [7:0] c, input int x, input int y);
    m_act[i] = 1; m_chr[i] = c; m_x[i] = x; m_y[i] = y;
  endtask

  task automatic cyc_idle();
    tick(); clr();
  endtask

  task automatic cyc_spawn(input logic [7:0] c, input int x, input int sp);
    tick(); clr();
    spawn_valid = 1'b1; spawn_char = c; spawn_x = 10'(x); spawn_speed = SPD_W'(sp);
  endtask

  task automatic cyc_key(input logic [7:0] c);
    tick(); clr();
    key_valid = 1'b1; key_char = c;
  endtask

  task automatic cyc_tick();
    tick(); clr();
    h_addr = 10'd0; v_addr = 10'd480;
  endtask

  task automatic scan(input int h, input int v);
    bit          f;
    logic [11:0] addr, fnt;
    int          col;
    tick(); clr();
    h_addr = 10'(h); v_addr = 10'(v);
    ref_render(h, v, f, addr, col);
    fnt = font(addr);
    want(1, S_ROM, int'(addr), $sformatf("rom_addr h%0d v%0d", h, v));
    want(2, S_PIX, f ? int'(fnt[col]) : 0, $sformatf("pix_on h%0d v%0d", h, v));
  endtask

  task automatic do_reset();
    tick(); clr(); reset = 1'b1;
    tick(); reset = 1'b0;
    model_clear();
  endtask

  int vl1[5] = '{5, 6, 13, 21, 22};
  int vl2[3] = '{6, 15, 16};
  int hl2[6] = '{103, 104, 108, 109, 112, 113};
  int hl3[4] = '{630, 631, 639, 640};
  int hl4[6] = '{115, 119, 120, 123, 124, 129};
  int h0;
  logic [11:0] f0;
  logic [7:0]  ch;

  initial begin
    model_clear();
    // reset state
    tick();
    want(0, S_RDY, 1, "rst spawn_ready"); want(0, S_ACT, 0, "rst active_cnt");
    want(0, S_HCNT, 0, "rst hit_cnt");    want(0, S_MCNT, 0, "rst miss_cnt");
    want(0, S_PIX, 0, "rst pix_on");      want(0, S_ROM, 0, "rst rom_addr");
    want(0, S_HIT, 0, "rst hit");         want(0, S_MISS, 0, "rst miss");
    want(0, S_WRONG, 0, "rst wrong");
    tick(); reset = 1'b0;

    // one falling glyph, then clamp and overlap priority
    cyc_spawn("A", 100, 2);
    want(1, S_ACT, 1, "spawn A active_cnt");
    cyc_idle();
    for (int k = 0; k < 3; k++) begin cyc_tick(); cyc_idle(); end
    model_set(0, "A", 100, 6);
    foreach (vl1[j]) for (int h = 99; h <= 109; h++) scan(h, vl1[j]);
    cyc_spawn("C", 104, 0);
    cyc_spawn("B", 700, 0);
    want(1, S_ACT, 3, "three active");
    cyc_idle();
    model_set(1, "C", 104, 0);
    model_set(2, "B", 631, 0);
    foreach (vl2[j]) foreach (hl2[k]) scan(hl2[k], vl2[j]);
    foreach (hl3[k]) scan(hl3[k], 0);
    cyc_idle(); cyc_idle();

    // full table, first-match kill, refill into the freed slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ch = (i == 3 || i == 7) ? 8'h41 : 8'(8'h61 + i);
      cyc_spawn(ch, i * 30, 0);
      model_set(i, ch, i * 30, 0);
    end
    want(1, S_RDY, 0, "full spawn_ready"); want(1, S_ACT, 16, "full active_cnt");
    cyc_spawn("X", 500, 0);
    want(0, S_RDY, 0, "full spawn_ready held");
    cyc_idle();
    want(0, S_ACT, 16, "full spawn refused");
    cyc_key("A");
    want(1, S_HIT, 1, "kill A hit"); want(1, S_WRONG, 0, "kill A wrong");
    want(1, S_HCNT, 1, "kill A hit_cnt"); want(1, S_ACT, 15, "kill A active_cnt");
    want(1, S_RDY, 1, "kill A spawn_ready");
    cyc_idle();
    want(1, S_HIT, 0, "hit one cycle");
    cyc_spawn("Q", 115, 0);
    cyc_idle();
    want(0, S_ACT, 16, "refill active_cnt");
    model_set(3, "Q", 115, 0);
    foreach (hl4[k]) scan(hl4[k], 0);
    cyc_key("A");
    want(1, S_HIT, 1, "kill second A"); want(1, S_HCNT, 2, "second A hit_cnt");
    cyc_key("A");
    want(1, S_WRONG, 1, "no A left wrong"); want(1, S_HIT, 0, "no A left hit");
    want(1, S_HCNT, 2, "no A left hit_cnt");
    cyc_idle(); cyc_idle();

    // bottom exit, kill-over-exit on the step cycle, spawn blocked on step
    do_reset();
    cyc_spawn("M", 0, 5);
    cyc_spawn("N", 200, 5);
    cyc_idle();
    cyc_tick(); cyc_idle();
    cyc_spawn("K", 400, 5);
    cyc_idle();
    for (int k = 0; k < 91; k++) begin cyc_tick(); cyc_idle(); end
    want(0, S_MCNT, 0, "no early miss"); want(0, S_ACT, 3, "three falling");
    model_set(0, "M", 0, 460); model_set(1, "N", 200, 460); model_set(2, "K", 400, 455);
    scan(0, 460); scan(0, 459); scan(400, 455); scan(400, 454);
    cyc_idle();
    cyc_tick();
    want(1, S_MISS, 1, "double exit miss"); want(1, S_MCNT, 1, "double exit miss_cnt");
    want(1, S_ACT, 1, "double exit active_cnt");
    cyc_idle();
    want(1, S_MISS, 0, "miss one cycle");
    tick(); clr();
    h_addr = 10'd0; v_addr = 10'd480;
    key_valid = 1'b1; key_char = "K";
    spawn_valid = 1'b1; spawn_char = "S"; spawn_x = 10'd10; spawn_speed = '0;
    want(0, S_RDY, 0, "step spawn_ready");
    want(1, S_HIT, 1, "step kill hit"); want(1, S_MISS, 0, "step kill miss");
    want(1, S_MCNT, 1, "step kill miss_cnt"); want(1, S_HCNT, 1, "step kill hit_cnt");
    want(1, S_ACT, 0, "step spawn refused"); want(1, S_WRONG, 0, "step kill wrong");
    tick(); clr();
    spawn_valid = 1'b1;
    want(0, S_RDY, 1, "post-step spawn_ready"); want(1, S_ACT, 1, "post-step spawn");
    cyc_idle();
    model_clear(); model_set(0, "S", 10, 0);
    scan(10, 0); scan(19, 0);
    cyc_key("Z");
    want(1, S_WRONG, 1, "key Z wrong"); want(1, S_HIT, 0, "key Z hit");
    want(1, S_HCNT, 1, "key Z hit_cnt"); want(1, S_MCNT, 1, "key Z miss_cnt");
    cyc_idle(); cyc_idle();

    // reset mid-line with five slots and a pending spawn/kill
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc_spawn(8'(8'h61 + i), i * 50, 0);
      model_set(i, 8'(8'h61 + i), i * 50, 0);
    end
    want(1, S_ACT, 5, "five active");
    cyc_idle();
    f0 = font({8'h61, 4'd0});
    h0 = 0;
    for (int c = 8; c >= 0; c--) if (f0[c]) h0 = c;
    scan(h0, 0);
    tick(); tick();
    tick();
    reset = 1'b1; spawn_valid = 1'b1; spawn_char = "R"; key_valid = 1'b1; key_char = "a";
    want(0, S_ACT, 0, "mid reset active_cnt"); want(0, S_PIX, 0, "mid reset pix_on");
    want(0, S_RDY, 1, "mid reset spawn_ready"); want(0, S_ROM, 0, "mid reset rom_addr");
    tick();
    tick(); reset = 1'b0; clr();
    want(0, S_RDY, 1, "post reset spawn_ready");
    want(1, S_ACT, 0, "post reset active_cnt"); want(1, S_HCNT, 0, "post reset hit_cnt");
    want(1, S_HIT, 0, "post reset hit");
    cyc_idle();

    repeat (4) tick();
    foreach (sbq[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: left unchecked, want %0h", sbq[i].nm, sbq[i].val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/falling_char_engine.md
FALLING_CHAR_ENGINE -- requirements
Module: falling_char_engine

Interface
REQ-001 Parameter SLOTS, default 16: number of independent character slots; legal range 1..64.
REQ-002 Parameter H_RES, default 640: visible pixels per line.
REQ-003 Parameter V_RES, default 480: visible lines per frame.
REQ-004 Parameter CHAR_W, default 9: glyph width in pixels; legal range 1..12.
REQ-005 Parameter CHAR_H, default 16: glyph height in lines, fixed at 16 (4-bit row index).
REQ-006 Parameter SPD_W, default 4: speed field width.
REQ-007 Parameter FRAME_DIV, default 1: frames per movement step; legal range 1..255.
REQ-008 pclk  in  1  pixel clock, all logic on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 spawn_valid  in  1  spawn request.
REQ-011 spawn_ready  out  1  a spawn is accepted this cycle if spawn_valid is also high.
REQ-012 spawn_char  in  8  ASCII code of the new character.
REQ-013 spawn_x  in  10  left pixel column of the new character.
REQ-014 spawn_speed  in  SPD_W  lines moved per step.
REQ-015 key_valid  in  1  one-cycle keystroke strobe.
REQ-016 key_char  in  8  ASCII code of the keystroke.
REQ-017 h_addr, v_addr  in  10 each  current scan coordinate from vga_ctrl.
REQ-018 rom_addr  out  12  font ROM address, {char[7:0], row[3:0]}.
REQ-019 rom_data  in  12  font row, valid one cycle after rom_addr; bit i = column i.
REQ-020 pix_on  out  1  foreground pixel.
REQ-021 hit, miss, wrong  out  1 each  one-cycle event pulses.
REQ-022 active_cnt  out  clog2(SLOTS+1)  number of occupied slots.
REQ-023 hit_cnt, miss_cnt  out  16 each  saturating event counters.

Function
REQ-024 Each slot holds active, char, x, y (10 bits), and speed.
REQ-025 spawn_ready SHALL be high iff at least one slot is free and the current cycle is not a step cycle.
REQ-026 A spawn SHALL be accepted when spawn_valid and spawn_ready are both high; it fills the lowest-index free slot with y=0.
REQ-027 On spawn, x SHALL be stored as min(spawn_x, H_RES-CHAR_W); a speed of 0 is legal and the character stays still.
REQ-028 Frame tick: the single cycle with h_addr==0 and v_addr==V_RES.
REQ-029 A 8-bit frame counter SHALL increment on each frame tick and wrap at FRAME_DIV-1; the step cycle is the frame tick on which the counter equals FRAME_DIV-1.
REQ-030 On a step cycle, every active slot SHALL apply y <= y+speed, computed 11 bits wide.
REQ-031 If the new y exceeds V_RES-CHAR_H, the slot SHALL be freed instead, and miss pulses once for the cycle regardless of how many slots left.
REQ-032 On key_valid, the lowest-index active slot whose char equals key_char SHALL be freed and hit pulses; if no slot matches, wrong pulses.
REQ-033 If key_valid coincides with a step cycle, the kill takes precedence for the matched slot: it is freed and counts as a hit only, never as a miss.
REQ-034 A slot freed in cycle N SHALL not be spawnable before cycle N+1.
REQ-035 Render stage 1 (registered): select the lowest-index active slot with x <= h_addr < x+CHAR_W and y <= v_addr < y+CHAR_H.
REQ-036 Stage 1 SHALL register rom_addr = {char, v_addr-y}, col = h_addr-x, and sel = match found.
REQ-037 Render stage 2: pix_on <= sel_d & rom_data[col_d].
REQ-038 Total pix_on latency SHALL be 2 cycles after h_addr/v_addr; with no match, rom_addr SHALL hold 0.
REQ-039 hit_cnt and miss_cnt SHALL increment on hit and miss respectively and saturate at 16'hFFFF.
REQ-040 active_cnt SHALL be updated in the cycle after any spawn, kill or step exit.

Reset
REQ-041 Reset SHALL clear all slots to inactive, the frame counter to 0, all counters and pulses to 0, rom_addr and pix_on to 0, and set spawn_ready high.
REQ-042 Reset asserted mid-frame SHALL abort any pending spawn or kill; the first step after release occurs FRAME_DIV frame ticks later.

Verification
REQ-043 Spawn 'A' at x=100, speed 2, FRAME_DIV=1; wait 3 frame ticks -> y=6, and pix_on follows font bits at v_addr 6..21, 2-cycle latency.
REQ-044 Fill all 16 slots -> spawn_ready=0, active_cnt=16; key 'A' matching slots 3 and 7 -> slot 3 freed, hit=1, next spawn lands in slot 3.
REQ-045 Slot with y=460 and speed 5 at a step -> freed, miss=1, miss_cnt=1; key 'Z' with no match -> wrong=1, counters unchanged.
REQ-046 spawn_x=700 -> stored x=631; two slots overlapping a pixel -> the lower-index slot's glyph is drawn.
REQ-047 key_valid on the step cycle matching a slot that would exit -> hit=1, miss=0; spawn_valid on a step cycle -> not accepted until the next cycle.
REQ-048 Assert reset with 5 active slots mid-line -> active_cnt=0, pix_on=0 the next cycle, spawn_ready=1.
